// File: rtl/wb_route_if.sv
// Result handshake bundle between execution unit, route controller and the two writeback paths.
interface wb_route_if #(
    parameter int unsigned DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_dst;
    logic          sel;
    logic          a_valid;
    logic          a_ready;
    logic          b_valid;
    logic          b_ready;
    logic [DW-1:0] out_data;

    // Controller side.
    modport slave (
        input  in_valid, in_data, in_dst, a_ready, b_ready,
        output in_ready, sel, a_valid, b_valid, out_data
    );

    // Producer / writeback side.
    modport master (
        output in_valid, in_data, in_dst, a_ready, b_ready,
        input  in_ready, sel, a_valid, b_valid, out_data
    );
endinterface

// File: rtl/wb_route_ctrl.sv
// In-order result router: buffers tagged results and steers the head entry to writeback A or B.
module wb_route_ctrl #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    wb_route_if.slave                 bus,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [CW-1:0]             cnt_a,
    output logic [CW-1:0]             cnt_b,
    output logic [CW-1:0]             stall_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = DW + 1;

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]   wr_ptr_nx_c, rd_ptr_nx_c;
    logic          full_c, empty_c, push_c, pop_a_c, pop_b_c, pop_c, stall_c;
    logic          head_nonempty_nx_c;
    logic [EW-1:0] head_nx_c;

    logic          a_valid_q, b_valid_q, sel_q;
    logic [DW-1:0] out_data_q;
    logic [CW-1:0] cnt_a_q, cnt_b_q, stall_q;

    // Pointer-based full/empty and handshake qualification; flush cancels both sides.
    always_comb begin
        full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_c = (wr_ptr_q == rd_ptr_q);
        push_c  = bus.in_valid && !full_c && !flush;
        pop_a_c = a_valid_q && bus.a_ready && !flush;
        pop_b_c = b_valid_q && bus.b_ready && !flush;
        pop_c   = pop_a_c || pop_b_c;
        stall_c = !flush && ((a_valid_q && !bus.a_ready) || (b_valid_q && !bus.b_ready));
    end

    // Next pointers and the entry that will sit at the head after this edge.
    always_comb begin
        wr_ptr_nx_c = wr_ptr_q;
        rd_ptr_nx_c = rd_ptr_q;
        if (flush) begin
            wr_ptr_nx_c = '0;
            rd_ptr_nx_c = '0;
        end else begin
            if (push_c) wr_ptr_nx_c = wr_ptr_q + (AW+1)'(1);
            if (pop_c)  rd_ptr_nx_c = rd_ptr_q + (AW+1)'(1);
        end
        head_nonempty_nx_c = (wr_ptr_nx_c != rd_ptr_nx_c);
        // The word being written this edge becomes head when nothing older remains.
        if (push_c && (rd_ptr_nx_c == wr_ptr_q)) head_nx_c = {bus.in_dst, bus.in_data};
        else                                     head_nx_c = mem[rd_ptr_nx_c[AW-1:0]];
    end

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr_q[AW-1:0]] <= {bus.in_dst, bus.in_data};
    end

    // Pointers, registered head decode and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            sel_q      <= 1'b0;
            out_data_q <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            stall_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_nx_c;
            rd_ptr_q  <= rd_ptr_nx_c;
            a_valid_q <= head_nonempty_nx_c && !head_nx_c[DW];
            b_valid_q <= head_nonempty_nx_c &&  head_nx_c[DW];
            if (head_nonempty_nx_c) begin
                sel_q      <= head_nx_c[DW];
                out_data_q <= head_nx_c[DW-1:0];
            end
            if (pop_a_c) cnt_a_q <= cnt_a_q + CW'(1);
            if (pop_b_c) cnt_b_q <= cnt_b_q + CW'(1);
            if (stall_c && !empty_c && (stall_q != {CW{1'b1}})) stall_q <= stall_q + CW'(1);
        end
    end

    assign bus.in_ready = !full_c;
    assign bus.a_valid  = a_valid_q;
    assign bus.b_valid  = b_valid_q;
    assign bus.sel      = sel_q;
    assign bus.out_data = out_data_q;
    assign occupancy    = wr_ptr_q - rd_ptr_q;
    assign cnt_a        = cnt_a_q;
    assign cnt_b        = cnt_b_q;
    assign stall_cnt    = stall_q;
endmodule

// File: tb/tb_wb_route_ctrl.sv
// Directed, table-driven check of wb_route_ctrl routing, back-pressure, flush and reset.
module tb_wb_route_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [2:0]  occupancy;
    logic [15:0] cnt_a, cnt_b, stall_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    wb_route_if #(.DW(32)) bus ();

    wb_route_ctrl #(.DW(32), .DEPTH(4), .CW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus.slave),
        .occupancy (occupancy),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        idst;
        logic [31:0] idata;
        logic        ar;
        logic        br;
        logic        e_av;
        logic        e_bv;
        logic        e_sel;
        logic [31:0] e_data;
        logic [2:0]  e_occ;
        logic        e_irdy;
        logic [15:0] e_ca;
        logic [15:0] e_cb;
        logic [15:0] e_st;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(logic iv, logic idst, logic [31:0] idata, logic ar, logic br,
                                logic av, logic bv, logic sel, logic [31:0] d, logic [2:0] occ,
                                logic irdy, logic [15:0] ca, logic [15:0] cb, logic [15:0] st);
        vec_t v;
        v.iv = iv; v.idst = idst; v.idata = idata; v.ar = ar; v.br = br;
        v.e_av = av; v.e_bv = bv; v.e_sel = sel; v.e_data = d; v.e_occ = occ;
        v.e_irdy = irdy; v.e_ca = ca; v.e_cb = cb; v.e_st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic dst, input logic [31:0] d,
                         input logic ar, input logic br);
        bus.in_valid = iv;
        bus.in_dst   = dst;
        bus.in_data  = d;
        bus.a_ready  = ar;
        bus.b_ready  = br;
    endtask

    // Inputs change #1 after posedge; outputs are sampled on the negedge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(1,0,32'h11,1,1, 0,0,0,32'h00,0,1, 0,0,0);
        vecs[1]  = mk(1,1,32'h22,1,1, 1,0,0,32'h11,1,1, 0,0,0);
        vecs[2]  = mk(0,0,32'h00,1,1, 0,1,1,32'h22,1,1, 1,0,0);
        vecs[3]  = mk(0,0,32'h00,1,1, 0,0,1,32'h22,0,1, 1,1,0);
        vecs[4]  = mk(1,1,32'h01,1,0, 0,0,1,32'h22,0,1, 1,1,0);
        vecs[5]  = mk(1,0,32'h02,1,0, 0,1,1,32'h01,1,1, 1,1,0);
        vecs[6]  = mk(0,0,32'h00,1,0, 0,1,1,32'h01,2,1, 1,1,1);
        vecs[7]  = mk(0,0,32'h00,1,0, 0,1,1,32'h01,2,1, 1,1,2);
        vecs[8]  = mk(0,0,32'h00,1,1, 0,1,1,32'h01,2,1, 1,1,3);
        vecs[9]  = mk(0,0,32'h00,1,1, 1,0,0,32'h02,1,1, 1,2,3);
        vecs[10] = mk(0,0,32'h00,0,1, 0,0,0,32'h02,0,1, 2,2,3);
        vecs[11] = mk(1,0,32'h31,0,1, 0,0,0,32'h02,0,1, 2,2,3);
        vecs[12] = mk(1,0,32'h32,0,1, 1,0,0,32'h31,1,1, 2,2,3);
        vecs[13] = mk(1,0,32'h33,0,1, 1,0,0,32'h31,2,1, 2,2,4);
        vecs[14] = mk(1,0,32'h34,0,1, 1,0,0,32'h31,3,1, 2,2,5);
        vecs[15] = mk(1,0,32'h35,0,1, 1,0,0,32'h31,4,0, 2,2,6);
        vecs[16] = mk(1,0,32'h35,1,1, 1,0,0,32'h31,4,0, 2,2,7);
        vecs[17] = mk(0,0,32'h00,0,1, 1,0,0,32'h32,3,1, 3,2,7);
        vecs[18] = mk(0,0,32'h00,1,1, 1,0,0,32'h32,3,1, 3,2,8);
        vecs[19] = mk(0,0,32'h00,1,1, 1,0,0,32'h33,2,1, 4,2,8);
        vecs[20] = mk(0,0,32'h00,1,1, 1,0,0,32'h34,1,1, 5,2,8);
        vecs[21] = mk(0,0,32'h00,1,1, 0,0,0,32'h34,0,1, 6,2,8);

        // Reset state
        rst_n = 1'b0;
        flush = 1'b0;
        drive(0, 0, 32'h0, 1, 1);
        @(negedge clk);
        chk("rst.occ",   32'(occupancy), 32'd0);
        chk("rst.irdy",  32'(bus.in_ready), 32'd1);
        chk("rst.av",    32'(bus.a_valid), 32'd0);
        chk("rst.bv",    32'(bus.b_valid), 32'd0);
        chk("rst.sel",   32'(bus.sel), 32'd0);
        chk("rst.data",  bus.out_data, 32'd0);
        chk("rst.cnt",   32'(cnt_a) | 32'(cnt_b) | 32'(stall_cnt), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Routing, back-pressure, full FIFO and drain
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].iv, vecs[i].idst, vecs[i].idata, vecs[i].ar, vecs[i].br);
            @(negedge clk);
            chk($sformatf("v%0d.av", i),   32'(bus.a_valid),  32'(vecs[i].e_av));
            chk($sformatf("v%0d.bv", i),   32'(bus.b_valid),  32'(vecs[i].e_bv));
            chk($sformatf("v%0d.sel", i),  32'(bus.sel),      32'(vecs[i].e_sel));
            chk($sformatf("v%0d.data", i), bus.out_data,      vecs[i].e_data);
            chk($sformatf("v%0d.occ", i),  32'(occupancy),    32'(vecs[i].e_occ));
            chk($sformatf("v%0d.irdy", i), 32'(bus.in_ready), 32'(vecs[i].e_irdy));
            chk($sformatf("v%0d.cnta", i), 32'(cnt_a),        32'(vecs[i].e_ca));
            chk($sformatf("v%0d.cntb", i), 32'(cnt_b),        32'(vecs[i].e_cb));
            chk($sformatf("v%0d.stall", i), 32'(stall_cnt),   32'(vecs[i].e_st));
            next_cycle();
        end

        // Streaming push+pop every cycle across pointer wrap
        for (int k = 0; k <= 10; k++) begin
            drive(k < 10, 0, 32'h40 + 32'(k), 1, 1);
            @(negedge clk);
            if (k > 0) begin
                chk($sformatf("strm%0d.occ", k),  32'(occupancy), 32'd1);
                chk($sformatf("strm%0d.av", k),   32'(bus.a_valid), 32'd1);
                chk($sformatf("strm%0d.data", k), bus.out_data, 32'h40 + 32'(k - 1));
            end
            next_cycle();
        end
        drive(0, 0, 32'h0, 1, 1);
        @(negedge clk);
        chk("strm.occ_end", 32'(occupancy), 32'd0);
        chk("strm.cnta",    32'(cnt_a), 32'd16);
        next_cycle();

        // Flush with a concurrent push while three entries are held
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 32'h50 + 32'(k), 0, 1);
            next_cycle();
        end
        drive(1, 0, 32'h99, 0, 1);
        flush = 1'b1;
        @(negedge clk);
        chk("fl.pre_occ",   32'(occupancy), 32'd3);
        chk("fl.pre_stall", 32'(stall_cnt), 32'd10);
        next_cycle();
        flush = 1'b0;
        drive(0, 0, 32'h0, 1, 1);
        @(negedge clk);
        chk("fl.occ",   32'(occupancy), 32'd0);
        chk("fl.av",    32'(bus.a_valid), 32'd0);
        chk("fl.bv",    32'(bus.b_valid), 32'd0);
        chk("fl.data",  bus.out_data, 32'h50);
        chk("fl.cnta",  32'(cnt_a), 32'd16);
        chk("fl.cntb",  32'(cnt_b), 32'd2);
        chk("fl.stall", 32'(stall_cnt), 32'd10);
        next_cycle();
        @(negedge clk);
        chk("fl.dropped", 32'(occupancy), 32'd0);
        next_cycle();

        // Asynchronous reset mid-stream with b_valid high
        drive(1, 1, 32'h60, 1, 0);
        next_cycle();
        drive(1, 1, 32'h61, 1, 0);
        next_cycle();
        drive(0, 0, 32'h0, 1, 0);
        @(negedge clk);
        chk("ar.pre_bv", 32'(bus.b_valid), 32'd1);
        next_cycle();
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar.bv",    32'(bus.b_valid), 32'd0);
        chk("ar.occ",   32'(occupancy), 32'd0);
        chk("ar.data",  bus.out_data, 32'd0);
        chk("ar.sel",   32'(bus.sel), 32'd0);
        chk("ar.cnt",   32'(cnt_a) | 32'(cnt_b) | 32'(stall_cnt), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        drive(0, 0, 32'h0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ar.idle%0d", k), 32'(bus.b_valid) | 32'(bus.a_valid), 32'd0);
            next_cycle();
        end
        chk("ar.cntb", 32'(cnt_b), 32'd0);
        drive(1, 1, 32'h70, 1, 1);
        next_cycle();
        drive(0, 0, 32'h0, 1, 1);
        @(negedge clk);
        chk("ar.new_bv",   32'(bus.b_valid), 32'd1);
        chk("ar.new_data", bus.out_data, 32'h70);
        next_cycle();
        @(negedge clk);
        chk("ar.new_cntb", 32'(cnt_b), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
